// File: rtl/qsys_ram_bist_master.sv
// ----------------------------------------------------------------------------
// qsys_ram_bist_master
//
// Avalon-MM memory BIST master. On an accepted start it writes the pattern
// (seed ^ address) to every word of an inclusive, wrap-capable address range,
// then reads the range back and counts mismatches in a saturating counter.
// A sticky abort ends the test early once the in-flight transfer completes.
//
// Ports
//   clk, reset_n             rising-edge clock, asynchronous active-low reset
//   start                    single-cycle test request (accepted in IDLE only)
//   first_addr, last_addr    inclusive word range, sampled on accepted start
//   seed                     pattern seed, sampled on accepted start
//   abort                    early-termination request
//   busy, done, pass         status: busy outside IDLE, one-cycle done, result
//   err_count                saturating mismatch count
//   avm_*                    Avalon-MM master (byteenable fixed at 4'hF)
//
// Optional build macro QSYS_RAM_BIST_ERR_CAPTURE_EN adds err_valid, err_addr
// and err_data, which capture the address and readdata of the first mismatch.
// ----------------------------------------------------------------------------
module qsys_ram_bist_master #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [31:0]       seed,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
    ,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic [31:0]       err_data
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [31:0]       seed_q, seed_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pass_q, pass_d;
    logic              abort_q, abort_d;

`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
    logic              ev_q, ev_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [31:0]       ed_q, ed_d;
`endif

    logic [31:0]       pattern;
    logic [ADDR_W-1:0] cur_inc;
    logic              at_last;
    logic              abort_hit;
    logic              mismatch;

    assign pattern  = seed_q ^ 32'(cur_q);
    assign cur_inc  = cur_q + ADDR_W'(1);
    assign at_last  = (cur_q == last_q);
    // An abort seen in the accepting cycle itself acts without a further delay.
    assign abort_hit = abort_q | abort;
    assign mismatch  = (avm_readdata != pattern);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
            ev_q    <= 1'b0;
            ea_q    <= '0;
            ed_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            first_q <= first_d;
            last_q  <= last_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            abort_q <= abort_d;
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
            ev_q    <= ev_d;
            ea_q    <= ea_d;
            ed_q    <= ed_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        first_d = first_q;
        last_d  = last_q;
        seed_d  = seed_q;
        err_d   = err_q;
        pass_d  = pass_q;
        abort_d = abort_q;
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
        ev_d    = ev_q;
        ea_d    = ea_q;
        ed_d    = ed_q;
`endif

        if (state_q != IDLE && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    first_d = first_addr;
                    last_d  = last_addr;
                    seed_d  = seed;
                    cur_d   = first_addr;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    abort_d = 1'b0;
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
                    ev_d    = 1'b0;
                    ea_d    = '0;
                    ed_d    = '0;
`endif
                    state_d = WR;
                end
            end

            WR: begin
                if (!avm_waitrequest) begin
                    if (abort_hit) begin
                        pass_d  = 1'b0;
                        state_d = DONE;
                    end else if (at_last) begin
                        cur_d   = first_q;
                        state_d = RD_REQ;
                    end else begin
                        cur_d   = cur_inc;
                    end
                end
            end

            RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
                        if (!ev_q) begin
                            ev_d = 1'b1;
                            ea_d = cur_q;
                            ed_d = avm_readdata;
                        end
`endif
                    end
                    if (abort_hit || at_last) begin
                        // pass must already be valid while DONE is showing.
                        pass_d  = !abort_hit && (err_d == '0);
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_inc;
                        state_d = RD_REQ;
                    end
                end
            end

            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign avm_byteenable = 4'hF;
    assign avm_chipselect = (state_q == WR) || (state_q == RD_REQ);
    assign avm_write      = (state_q == WR);
    assign avm_read       = (state_q == RD_REQ);
    assign avm_address    = cur_q;
    assign avm_writedata  = (state_q == WR) ? pattern : '0;

`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
    assign err_valid = ev_q;
    assign err_addr  = ea_q;
    assign err_data  = ed_q;
`endif

endmodule

// File: tb/tb_qsys_ram_bist_master.sv
// ----------------------------------------------------------------------------
// tb_qsys_ram_bist_master
//
// Directed bench for qsys_ram_bist_master with a behavioural Avalon-MM slave
// (optional random stalls, optional stuck-at-1 fault on bit 0 of word 0x005).
// Define QSYS_RAM_BIST_ERR_CAPTURE_EN to exercise the error-capture ports.
// ----------------------------------------------------------------------------
module tb_qsys_ram_bist_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] first_addr;
    logic [11:0] last_addr;
    logic [31:0] seed;
    logic        abort;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect, avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
    logic        err_valid;
    logic [11:0] err_addr;
    logic [31:0] err_data;
`endif

    logic        wait_q = 1'b0;
    logic        force_wait = 1'b0;
    logic        rdv_q = 1'b0;
    logic [31:0] rdata_q = '0;
    bit          stall_en = 1'b0;
    bit          fault_en = 1'b0;

    assign avm_waitrequest   = wait_q | force_wait;
    assign avm_readdatavalid = rdv_q;
    assign avm_readdata      = rdata_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qsys_ram_bist_master #(
        .ADDR_W(12),
        .ERR_W (16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .last_addr        (last_addr),
        .seed             (seed),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .avm_address      (avm_address),
        .avm_byteenable   (avm_byteenable),
        .avm_chipselect   (avm_chipselect),
        .avm_write        (avm_write),
        .avm_read         (avm_read),
        .avm_writedata    (avm_writedata),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
        ,
        .err_valid        (err_valid),
        .err_addr         (err_addr),
        .err_data         (err_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave model: samples requests at negedge, applies them at posedge.
    // ------------------------------------------------------------------
    logic [31:0] mem [0:4095];
    logic [11:0] wr_log[$];
    logic [31:0] wd_log[$];
    logic [11:0] rd_log[$];
    int          wl = 0;
    bit          prev_stall = 1'b0;
    logic        p_cs, p_wr, p_rd;
    logic [11:0] p_addr;
    logic [31:0] p_wd;
    bit          acc_wr, acc_rd, stalled;
    logic [11:0] s_addr;
    logic [31:0] s_wd;

    always begin
        @(negedge clk);
        if (prev_stall && reset_n) begin
            check("stall_cs",   avm_chipselect, p_cs);
            check("stall_wr",   avm_write,      p_wr);
            check("stall_rd",   avm_read,       p_rd);
            check("stall_addr", avm_address,    p_addr);
            check("stall_wd",   avm_writedata,  p_wd);
        end
        stalled    = reset_n && avm_chipselect && avm_waitrequest;
        prev_stall = stalled;
        p_cs   = avm_chipselect;
        p_wr   = avm_write;
        p_rd   = avm_read;
        p_addr = avm_address;
        p_wd   = avm_writedata;
        acc_wr = reset_n && avm_chipselect && avm_write && !avm_waitrequest;
        acc_rd = reset_n && avm_chipselect && avm_read  && !avm_waitrequest;
        s_addr = avm_address;
        s_wd   = avm_writedata;
        @(posedge clk);
        if (!reset_n) begin
            wait_q <= 1'b0;
            rdv_q  <= 1'b0;
            wl = 0;
        end else begin
            rdv_q <= acc_rd;
            if (acc_wr) begin
                mem[s_addr] = s_wd;
                wr_log.push_back(s_addr);
                wd_log.push_back(s_wd);
            end
            if (acc_rd) begin
                rdata_q <= (fault_en && s_addr == 12'h005) ? (mem[s_addr] | 32'h1) : mem[s_addr];
                rd_log.push_back(s_addr);
            end
            if (acc_wr || acc_rd) begin
                wl = stall_en ? int'($urandom_range(0, 3)) : 0;
                wait_q <= (wl != 0);
            end else if (stalled && wl > 0) begin
                wl = wl - 1;
                wait_q <= (wl != 0);
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete();
        wd_log.delete();
        rd_log.delete();
    endtask

    task automatic run_test(input logic [11:0] f, input logic [11:0] l, input logic [31:0] s,
                            input bit ab_start, input logic exp_pass, input int exp_err,
                            input string tag);
        logic [11:0] exp_a[$];
        logic [11:0] a;
        bit          seen;
        clear_logs();
        @(posedge clk); #1;
        first_addr = f; last_addr = l; seed = s; start = 1'b1; abort = ab_start;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, seen, 1'b1);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_errcnt"}, err_count, 64'(exp_err));
        a = f;
        forever begin
            exp_a.push_back(a);
            if (a == l) break;
            a = a + 12'd1;
        end
        check({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_a.size()));
        check({tag, "_nrd"}, 64'(rd_log.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < wr_log.size()) begin
                check({tag, "_wa"}, wr_log[i], exp_a[i]);
                check({tag, "_wd"}, wd_log[i], s ^ {20'h0, exp_a[i]});
            end
            if (i < rd_log.size()) check({tag, "_ra"}, rd_log[i], exp_a[i]);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int  n0;
    bit  hit;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        first_addr = '0; last_addr = '0; seed = '0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err",  err_count, 16'h0);
        check("rst_cs",   avm_chipselect, 1'b0);
        check("rst_wr",   avm_write, 1'b0);
        check("rst_rd",   avm_read, 1'b0);
        check("rst_addr", avm_address, 12'h0);
        check("rst_wd",   avm_writedata, 32'h0);
        check("rst_be",   avm_byteenable, 4'hF);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic zero-wait test
        run_test(12'h010, 12'h013, 32'hA5A5A5A5, 1'b0, 1'b1, 0, "t1");
        check("t1_wa2", (wr_log.size() > 2) ? wr_log[2] : 12'h0, 12'h012);
        check("t1_wd2", (wd_log.size() > 2) ? wd_log[2] : 32'h0, 32'hA5A5A5B7);

        // Wrap through top of address space; abort together with start is ignored
        run_test(12'hFFE, 12'h001, 32'h3C3C0000, 1'b1, 1'b1, 0, "t2");
        check("t2_wa0", (wr_log.size() > 0) ? wr_log[0] : 12'h0, 12'hFFE);
        check("t2_wa2", (wr_log.size() > 2) ? wr_log[2] : 12'hFFF, 12'h000);

        // Stuck bit at 0x005
        fault_en = 1'b1;
        run_test(12'h000, 12'h00F, 32'h12345679, 1'b0, 1'b0, 1, "t3");
        fault_en = 1'b0;
`ifdef QSYS_RAM_BIST_ERR_CAPTURE_EN
        check("t3_ev", err_valid, 1'b1);
        check("t3_ea", err_addr, 12'h005);
        check("t3_ed", err_data, 32'h1234567D);
`endif

        // Random stalls
        stall_en = 1'b1;
        run_test(12'h100, 12'h107, 32'hDEADBEEF, 1'b0, 1'b1, 0, "t4");
        stall_en = 1'b0;
        @(posedge clk); #1;
        force_wait = 1'b0;
        repeat (5) @(posedge clk);

        // Abort during a stalled write
        clear_logs();
        @(posedge clk); #1;
        first_addr = 12'h020; last_addr = 12'h02F; seed = 32'h0F0F0F0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_log.size() >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_reach", hit, 1'b1);
        @(posedge clk); #1;
        force_wait = 1'b1;
        n0 = wr_log.size();
        check("t5_n0", 64'(n0), 64'd4);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(posedge clk); #1 force_wait = 1'b0;
        @(negedge clk);
        check("t5_held_wr", avm_write, 1'b1);
        check("t5_held_addr", avm_address, 12'h024);
        check("t5_not_done", done, 1'b0);
        @(negedge clk);
        check("t5_done", done, 1'b1);
        check("t5_pass", pass, 1'b0);
        repeat (6) @(negedge clk);
        check("t5_nwr", 64'(wr_log.size()), 64'(n0 + 1));
        check("t5_lastwa", (wr_log.size() > n0) ? wr_log[n0] : 12'h0, 12'h024);
        check("t5_nrd", 64'(rd_log.size()), 64'd0);
        check("t5_idle", busy, 1'b0);

        // Reset during RD_WAIT
        clear_logs();
        @(posedge clk); #1;
        first_addr = 12'h030; last_addr = 12'h033; seed = 32'h55AA55AA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_log.size() >= 1) begin
                hit = 1'b1;
                break;
            end
        end
        check("t6_reach", hit, 1'b1);
        check("t6_rdwait", {busy, avm_read, avm_chipselect}, 3'b100);
        #1 reset_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_pass", pass, 1'b0);
        check("t6_err",  err_count, 16'h0);
        check("t6_ctl",  {avm_chipselect, avm_write, avm_read}, 3'b000);
        check("t6_addr", avm_address, 12'h0);
        check("t6_be",   avm_byteenable, 4'hF);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_test(12'h030, 12'h033, 32'h55AA55AA, 1'b0, 1'b1, 0, "t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
